bullet_controller: RTL

BULLET_CONTROLLER -- requirements
Module: bullet_controller

---
 rtl/bullet_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bullet_controller.sv
// Horizontal bullet sprite controller: launch on fire, move per frame_tick,
// flash on hit, then cool down before the next launch is accepted.
module bullet_controller #(
    parameter int unsigned SPEED       = 4,
    parameter int unsigned X_MIN       = 8,
    parameter int unsigned X_MAX       = 631,
    parameter int unsigned HIT_FRAMES  = 8,
    parameter int unsigned COOL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [9:0] gun_x,
    input  logic [8:0] gun_y,
    input  logic       dir,
    input  logic       hit,
    output logic [9:0] bullet_x,
    output logic [8:0] bullet_y,
    output logic       active,
    output logic       flash,
    output logic       fire_ack,
    output logic       expired
);

    localparam int unsigned MAXF  = (HIT_FRAMES > COOL_FRAMES) ? HIT_FRAMES : COOL_FRAMES;
    localparam int unsigned CNT_W = (MAXF > 1) ? $clog2(MAXF + 1) : 1;
    localparam logic [CNT_W-1:0] HIT_LAST  = CNT_W'((HIT_FRAMES > 0) ? HIT_FRAMES - 1 : 0);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'((COOL_FRAMES > 0) ? COOL_FRAMES - 1 : 0);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] LEFT_LIM11 = 11'(X_MIN + SPEED);
    localparam logic [10:0] SPEED11 = 11'(SPEED);

    typedef enum logic [1:0] {
        IDLE,
        FLY,
        HIT,
        COOL
    } state_t;

    state_t           state_q;
    logic [9:0]       bullet_x_q;
    logic [8:0]       bullet_y_q;
    logic             dir_q;
    logic             active_q;
    logic             flash_q;
    logic             fire_ack_q;
    logic             expired_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic [10:0] x11_d;
    logic [10:0] sum11_d;
    logic [9:0]  step_x_d;
    logic        edge_d;

    // Out-of-range launches expire on the first tick whatever the direction.
    always_comb begin
        x11_d    = {1'b0, bullet_x_q};
        sum11_d  = x11_d + SPEED11;
        step_x_d = dir_q ? (bullet_x_q - 10'(SPEED)) : (bullet_x_q + 10'(SPEED));
        edge_d   = (x11_d < XMIN11) || (x11_d > XMAX11) ||
                   (dir_q ? (x11_d < LEFT_LIM11) : (sum11_d > XMAX11));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bullet_x_q  <= '0;
            bullet_y_q  <= '0;
            dir_q       <= 1'b0;
            active_q    <= 1'b0;
            flash_q     <= 1'b0;
            fire_ack_q  <= 1'b0;
            expired_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            fire_ack_q <= 1'b0;
            expired_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        bullet_x_q <= gun_x;
                        bullet_y_q <= gun_y;
                        dir_q      <= dir;
                        fire_ack_q <= 1'b1;
                        active_q   <= 1'b1;
                        state_q    <= FLY;
                    end
                end
                FLY: begin
                    if (hit) begin
                        flash_q     <= 1'b1;
                        frame_cnt_q <= '0;
                        state_q     <= HIT;
                    end else if (frame_tick) begin
                        if (edge_d) begin
                            active_q    <= 1'b0;
                            expired_q   <= 1'b1;
                            frame_cnt_q <= '0;
                            state_q     <= COOL;
                        end else begin
                            bullet_x_q <= step_x_d;
                        end
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == HIT_LAST) begin
                            flash_q     <= 1'b0;
                            active_q    <= 1'b0;
                            expired_q   <= 1'b1;
                            frame_cnt_q <= '0;
                            state_q     <= COOL;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                COOL: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == COOL_LAST) begin
                            frame_cnt_q <= '0;
                            state_q     <= IDLE;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bullet_x = bullet_x_q;
    assign bullet_y = bullet_y_q;
    assign active   = active_q;
    assign flash    = flash_q;
    assign fire_ack = fire_ack_q;
    assign expired  = expired_q;

endmodule
